// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer behind the UART receiver: synchronizes the ready strobe, checks parity,
// queues {perr, data} and keeps sticky overflow plus a saturating parity-error count.
// Optional build macro UART_RX_FIFO_PERR_DROP_EN discards words that fail parity instead of storing them.
module uart_rx_fifo #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ODD_PARITY = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8:0]               rx_word,
    input  logic                     rx_ready,
    input  logic                     rd_en,
    input  logic                     clr_stat,
    output logic [7:0]               rd_data,
    output logic                     rd_perr,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               perr_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
`ifdef UART_RX_FIFO_PERR_DROP_EN
    localparam int unsigned EW = 8;
`else
    localparam int unsigned EW = 9;
`endif

    logic          sync1_q, rdy_s_q, rdy_prev_q;
    logic [1:0]    fill_q;
    logic          armed_q, armed_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    perr_cnt_q, perr_cnt_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] entry, head;

    logic push_ev, perr, store_req, do_push, do_pop, ovf_set;

    assign push_ev = rdy_s_q & ~rdy_prev_q & armed_q;
    assign perr    = (^rx_word) ^ (ODD_PARITY != 0);

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

`ifdef UART_RX_FIFO_PERR_DROP_EN
    assign store_req = push_ev & ~perr;
    assign entry     = rx_word[7:0];
    assign rd_perr   = 1'b0;
`else
    assign store_req = push_ev;
    assign entry     = {perr, rx_word[7:0]};
    assign rd_perr   = empty ? 1'b0 : head[8];
`endif

    assign rd_data    = empty ? 8'h00 : head[7:0];
    assign overflow   = overflow_q;
    assign perr_count = perr_cnt_q;

    // When full, a push is only taken alongside a pop so the slot frees first.
    assign do_pop  = rd_en & ~empty;
    assign do_push = store_req & (~full | rd_en);
    assign ovf_set = store_req & full & ~rd_en;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        perr_cnt_d = perr_cnt_q;
        // Only arm on a low that came from the input, not from the reset value of the sync flops.
        armed_d    = armed_q | (fill_q[1] & ~rdy_s_q);
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (clr_stat) begin
            overflow_d = 1'b0;
            perr_cnt_d = 8'h00;
        end
        if (ovf_set) overflow_d = 1'b1;
        if (push_ev && perr) begin
            if (clr_stat)                 perr_cnt_d = 8'h01;
            else if (perr_cnt_q != 8'hFF) perr_cnt_d = perr_cnt_q + 8'h01;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b0;
            rdy_s_q    <= 1'b0;
            rdy_prev_q <= 1'b0;
            fill_q     <= 2'b00;
            armed_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            perr_cnt_q <= 8'h00;
        end else begin
            sync1_q    <= rx_ready;
            rdy_s_q    <= sync1_q;
            rdy_prev_q <= rdy_s_q;
            fill_q     <= {fill_q[0], 1'b1};
            armed_q    <= armed_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            perr_cnt_q <= perr_cnt_d;
        end
    end

    // Storage is not reset; reads are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= entry;
    end

endmodule
